pam4_tx_encoder: RTL
====================

Name: pam4_tx_encoder

Overview:
- Transmit-side counterpart of the receive chain made up of the DFE, the PAM4 decoder and the Gray decoder.
- Packs a serial bit stream into 2-bit symbols, Gray-encodes each pair into a PAM4 level index, and maps that index to a signed 8-bit voltage.
- Before payload, emits a training preamble; a copy of the preamble drives the DFE training-data input.
- Sits between the bit source and the channel model in the TX Qsys system.

Parameters:
- TRAIN_LEN, 64, number of training symbols per preamble (0 = skip training).
- LVL_STEP, 32, voltage step; level idx k maps to (2k-3)*LVL_STEP; must satisfy 3*LVL_STEP <= 127.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begin a (re)training preamble then payload.
- stop  in  1  pulse; return to idle.
- data_in  in  1  payload bit.
- data_in_valid  in  1  data_in qualifier.
- data_in_ready  out  1  high only in DATA state.
- symbol_out  out  2  PAM4 level index (Gray-coded).
- symbol_out_valid  out  1  symbol_out qualifier.
- voltage_level_out  out  8  signed two's-complement channel voltage.
- voltage_level_out_valid  out  1  qualifier, same cycle as symbol_out_valid.
- train_data_out  out  8  training voltage for the DFE train input.
- train_data_out_valid  out  1  high only for preamble symbols.
- training  out  1  high while in TRAIN.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; FSM in IDLE.
  - Pair register and bit flag cleared; training counter 0; LFSR loaded with seed.
- FSM states: IDLE, TRAIN, DATA.
- IDLE:
  - No valid outputs; data_in ignored.
  - start: go to TRAIN, or to DATA if TRAIN_LEN==0.
- TRAIN:
  - One symbol per cycle, every cycle, for exactly TRAIN_LEN cycles.
  - symbol_out_valid, voltage_level_out_valid and train_data_out_valid are all asserted; train_data_out equals voltage_level_out.
  - After the TRAIN_LEN-th symbol, go to DATA.
- DATA:
  - data_in_ready=1. Each data_in_valid cycle captures one bit.
  - The first bit of a pair is the MSB (b1) and is held in a flag. The second bit (b0) completes the pair.
  - Level idx = b1b0 XOR (b1b0>>1): 00->0, 01->1, 11->2, 10->3.
  - Voltage for idx 0..3 at default step: 0xA0, 0xE0, 0x20, 0x60 (-96, -32, +32, +96).
  - Latency: outputs are registered, valid the cycle after the second bit is accepted, and high for one cycle per symbol.
  - Gaps in data_in_valid are allowed; the pending half-pair is held indefinitely.
- Control precedence:
  - stop wins over start in the same cycle.
  - stop, in any state: go to IDLE next cycle; discard the half-pair; no symbol is emitted for it.
  - start in TRAIN or DATA: restart the preamble. Counter reset, LFSR reseeded, half-pair discarded.
  - A bit arriving on the same cycle as start or stop is dropped.
- Arithmetic:
  - The voltage is computed in 9 bits signed and truncated to 8 bits; parameter constraint guarantees no overflow.
  - The training counter is $clog2(TRAIN_LEN+1) bits wide and saturates on completion.

Optional Feature:
- Macro: TX_PRBS_TRAIN_EN.
- Defined: training symbols come from a PRBS7 LFSR.
  - Polynomial x^7+x^6+1, seed 7'h7F.
  - Advance 2 steps per symbol; the first output bit is b1.
  - The bit pair is Gray-mapped exactly as payload.
- Undefined: the training pattern is fixed alternating idx 0,3,0,3,... (0xA0, 0x60, ...), starting with idx 0. No LFSR is instantiated.

Decomposition:
- Package pam4_tx_pkg:
  - state enum typedef (IDLE/TRAIN/DATA);
  - function bin2gray(2b)->2b;
  - function idx2volt(idx, step)->8b signed;
  - PRBS7 seed/tap constants.
- One sub-module, prbs7_gen: enable, reseed, 2-bit output per step; instantiated only under TX_PRBS_TRAIN_EN.

Test Plan:
- Reset mid-DATA with a half-pair pending -> all outputs 0 immediately. After release, start with TRAIN_LEN=0 then bits 1,0 -> idx 3, voltage 0x60, one cycle after the second bit.
- TRAIN_LEN=4, no macro, start -> 4 consecutive valid symbols 0,3,0,3. train_data_out = 0xA0, 0x60, 0xA0, 0x60. training high for 4 cycles. data_in_ready rises on cycle 5.
- With TX_PRBS_TRAIN_EN, TRAIN_LEN=64 -> symbols match the golden PRBS7 model from seed 7'h7F. A second start reproduces the identical sequence.
- DATA, bits 0,0,0,1,1,1,1,0 with idle gaps between valids -> idx 0,1,2,3; voltages 0xA0, 0xE0, 0x20, 0x60; exactly 4 valid pulses.
- Single bit 1, then stop, then start (TRAIN_LEN=0), then bits 0,1 -> one symbol, idx 1 (0xE0); the stale half-pair is not emitted.
- start and stop asserted together in DATA -> IDLE next cycle; no training symbols; data_in_ready=0.

Source files
------------

// File: rtl/pam4_tx_pkg.sv
// pam4_tx_pkg: shared state type, Gray/voltage helpers and PRBS7 constants for the PAM4 transmitter.
package pam4_tx_pkg;
  typedef enum logic [1:0] {IDLE, TRAIN, DATA} state_t;
  localparam logic [6:0] PRBS_SEED = 7'h7F;
  localparam int PRBS_TAP_HI = 6;
  localparam int PRBS_TAP_LO = 5;
  function automatic logic [1:0] bin2gray(input logic [1:0] b);
    return b ^ (b >> 1);
  endfunction
  // 9-bit signed intermediate; 3*step <= 127 keeps the result inside 8 bits.
  function automatic logic [7:0] idx2volt(input logic [1:0] idx, input int step);
    logic signed [8:0] v;
    v = 9'((2 * int'(idx) - 3) * step);
    return v[7:0];
  endfunction
endpackage

// File: rtl/prbs7_gen.sv
// prbs7_gen: x^7+x^6+1 LFSR yielding two bits (b1 first) per enabled step; reseed takes effect the same cycle.
module prbs7_gen
  import pam4_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_en,
  input  logic       i_reseed,
  output logic [1:0] o_bits
);
  logic [6:0] r_lfsr, w_base, w_s1, w_s2;
  logic w_b1, w_b0;
  always_comb begin
    w_base = i_reseed ? PRBS_SEED : r_lfsr;
    w_b1 = w_base[PRBS_TAP_HI] ^ w_base[PRBS_TAP_LO];
    w_s1 = {w_base[5:0], w_b1};
    w_b0 = w_s1[PRBS_TAP_HI] ^ w_s1[PRBS_TAP_LO];
    w_s2 = {w_s1[5:0], w_b0};
    o_bits = {w_b1, w_b0};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_lfsr <= PRBS_SEED;
    else if (i_en) r_lfsr <= w_s2;
    else if (i_reseed) r_lfsr <= PRBS_SEED;
endmodule

// File: rtl/pam4_tx_encoder.sv
// pam4_tx_encoder: preamble + bit-pair Gray/PAM4 voltage encoder.
// TX_PRBS_TRAIN_EN selects a PRBS7 preamble instead of the fixed 0,3,0,3 pattern.
module pam4_tx_encoder
  import pam4_tx_pkg::*;
#(
  parameter int TRAIN_LEN = 64,
  parameter int LVL_STEP  = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [1:0] symbol_out,
  output logic       symbol_out_valid,
  output logic [7:0] voltage_level_out,
  output logic       voltage_level_out_valid,
  output logic [7:0] train_data_out,
  output logic       train_data_out_valid,
  output logic       training
);
  localparam int CW = TRAIN_LEN > 0 ? $clog2(TRAIN_LEN + 1) : 1;
  localparam logic [CW-1:0] TL = CW'(TRAIN_LEN);
  state_t r_state;
  logic [CW-1:0] r_cnt, w_train_num;
  logic r_half, r_b1, r_ready, r_sym_v, r_train_v, r_training;
  logic [1:0] r_sym, w_train_idx, w_idx;
  logic [7:0] r_volt, r_train_data, w_volt;
  logic w_go, w_train_sym, w_data_sym, w_emit;
  assign w_go = start & ~stop;
  // The start cycle itself emits preamble symbol 0, so training and valid line up.
  assign w_train_sym = (TRAIN_LEN > 0) && (w_go || (!start && !stop && r_state == TRAIN && r_cnt != TL));
  assign w_data_sym = !start && !stop && r_state == DATA && data_in_valid && r_half;
  assign w_emit = w_train_sym | w_data_sym;
  assign w_train_num = w_go ? '0 : r_cnt;
`ifdef TX_PRBS_TRAIN_EN
  logic [1:0] w_prbs_bits;
  prbs7_gen u_prbs (
    .clk(clk), .reset_n(reset_n), .i_en(w_train_sym), .i_reseed(w_go), .o_bits(w_prbs_bits)
  );
  assign w_train_idx = bin2gray(w_prbs_bits);
`else
  assign w_train_idx = w_train_num[0] ? 2'd3 : 2'd0;
`endif
  assign w_idx = w_train_sym ? w_train_idx : bin2gray({r_b1, data_in});
  assign w_volt = idx2volt(w_idx, LVL_STEP);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_half <= 1'b0;
      r_b1 <= 1'b0;
      r_ready <= 1'b0;
      r_training <= 1'b0;
      r_sym_v <= 1'b0;
      r_train_v <= 1'b0;
      r_sym <= '0;
      r_volt <= '0;
      r_train_data <= '0;
    end else begin
      r_sym_v <= w_emit;
      r_train_v <= w_train_sym;
      r_sym <= w_emit ? w_idx : '0;
      r_volt <= w_emit ? w_volt : '0;
      r_train_data <= w_train_sym ? w_volt : '0;
      if (stop) begin
        r_state <= IDLE;
        r_half <= 1'b0;
        r_ready <= 1'b0;
        r_training <= 1'b0;
      end else if (start) begin
        r_state <= TRAIN_LEN > 0 ? TRAIN : DATA;
        r_half <= 1'b0;
        r_ready <= TRAIN_LEN == 0;
        r_training <= TRAIN_LEN > 0;
      end else if (r_state == TRAIN && r_cnt == TL) begin
        r_state <= DATA;
        r_ready <= 1'b1;
        r_training <= 1'b0;
      end else if (r_state == DATA && data_in_valid) begin
        r_half <= ~r_half;
        r_b1 <= data_in;
      end
      if (w_train_sym) r_cnt <= w_train_num + 1'b1;
      else if (w_go) r_cnt <= '0;
    end
  end
  assign data_in_ready = r_ready;
  assign symbol_out = r_sym;
  assign symbol_out_valid = r_sym_v;
  assign voltage_level_out = r_volt;
  assign voltage_level_out_valid = r_sym_v;
  assign train_data_out = r_train_data;
  assign train_data_out_valid = r_train_v;
  assign training = r_training;
endmodule
